// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
//
// Multi-cycle processor control unit. A Moore FSM steps each instruction
// through fetch, decode and one to three execution states, driving the
// datapath enables and mux selects for every cycle.
//
// Optional feature:
//   MC_CONTROL_JAL_EN  when defined, opcode 000011 (JAL) is executed through
//                      a dedicated JAL state (encoding 12); when undefined it
//                      is reported as an illegal opcode.
//
// Ports:
//   clk            in   system clock, all state changes on the rising edge
//   rst            in   synchronous active-high reset
//   opcode         in   OP_W-bit instruction-register opcode field
//   mem_ready      in   memory access completes this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load when the ALU zero flag is set (branch)
//   i_or_d         out  memory address select: 0 = PC, 1 = ALU result
//   mem_read       out  memory read request
//   mem_write      out  memory write request
//   ir_write       out  instruction register load
//   reg_write      out  register file write
//   alu_src_a      out  ALU A select: 0 = PC, 1 = register A
//   alu_src_b      out  ALU B select (2 bits)
//   alu_op         out  ALU operation class (2 bits)
//   pc_source      out  PC next-value select (2 bits)
//   mem_to_reg     out  register write-data select (2 bits)
//   reg_dst        out  register write-address select (2 bits)
//   illegal_op     out  one-cycle pulse in DECODE on an unsupported opcode
//   state          out  current FSM state, for debug
//
// Handshake: mem_ready is a completion strobe. FETCH, MEM_READ and
// MEM_WRITE keep their request asserted and hold state until the cycle in
// which mem_ready is 1; that cycle is the last cycle of the access.
// -----------------------------------------------------------------------------
module mc_control #(
   parameter int OP_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] opcode,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            i_or_d,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_source,
   output logic [1:0]      mem_to_reg,
   output logic [1:0]      reg_dst,
   output logic            illegal_op,
   output logic [3:0]      state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_EXEC_I    = 4'd10,
      S_I_WB      = 4'd11,
      S_JAL       = 4'd12
   } state_t;

   localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
`ifdef MC_CONTROL_JAL_EN
   localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b000011);
`endif

   state_t r_state;
   state_t w_next_state;
   logic   w_decode_illegal;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. opcode is only looked at in DECODE and MEM_ADDR; every
   // other state moves on regardless of what the instruction register holds.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state     = S_FETCH;
      w_decode_illegal = 1'b0;
      case (r_state)
         S_FETCH:     w_next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               w_next_state = S_MEM_ADDR;
            end else if (opcode == OP_R) begin
               w_next_state = S_EXEC_R;
            end else if (opcode == OP_BEQ) begin
               w_next_state = S_BRANCH;
            end else if (opcode == OP_J) begin
               w_next_state = S_JUMP;
            end else if (opcode == OP_ADDI) begin
               w_next_state = S_EXEC_I;
`ifdef MC_CONTROL_JAL_EN
            end else if (opcode == OP_JAL) begin
               w_next_state = S_JAL;
`endif
            end else begin
               w_next_state     = S_FETCH;
               w_decode_illegal = 1'b1;
            end
         end
         // A memory-class opcode that changed after DECODE is abandoned
         // rather than guessed at.
         S_MEM_ADDR: begin
            if (opcode == OP_LW) begin
               w_next_state = S_MEM_READ;
            end else if (opcode == OP_SW) begin
               w_next_state = S_MEM_WRITE;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_MEM_READ:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    w_next_state = S_FETCH;
         S_MEM_WRITE: w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXEC_R:    w_next_state = S_R_WB;
         S_R_WB:      w_next_state = S_FETCH;
         S_BRANCH:    w_next_state = S_FETCH;
         S_JUMP:      w_next_state = S_FETCH;
         S_EXEC_I:    w_next_state = S_I_WB;
         S_I_WB:      w_next_state = S_FETCH;
         S_JAL:       w_next_state = S_FETCH;
         default:     w_next_state = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic. Everything defaults to 0. While rst is high the enables are
   // held off and the selects show their FETCH values so the datapath sits in
   // a known, harmless configuration.
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      mem_to_reg    = 2'b00;
      reg_dst       = 2'b00;
      illegal_op    = 1'b0;
      if (rst) begin
         alu_src_b = 2'b01;
      end else begin
         case (r_state)
            // PC+4 is computed every fetch cycle but only committed, together
            // with the instruction, in the cycle memory delivers it.
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b  = 2'b11;
               illegal_op = w_decode_illegal;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 2'b01;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_I_WB: begin
               reg_write = 1'b1;
            end
`ifdef MC_CONTROL_JAL_EN
            // Link address goes to the link register while the PC jumps.
            S_JAL: begin
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
               pc_write   = 1'b1;
               pc_source  = 2'b10;
            end
`endif
            default: begin
            end
         endcase
      end
   end

   assign state = r_state;

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
//
// Directed testbench for mc_control. Each scenario task drives the FSM and
// compares state and the packed control word against hand-written values.
// Control word layout (MSB first):
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
//   alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], mem_to_reg[1:0],
//   reg_dst[1:0], illegal_op
// -----------------------------------------------------------------------------
module tb_mc_control;

   // --------------------------------------------------------------------------
   // Clock / reset
   // --------------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       mem_ready;
   logic [5:0] opcode;

   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic       ir_write, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source, mem_to_reg, reg_dst;
   logic [3:0] state;
   logic [18:0] w_ctrl;

   mc_control dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .illegal_op    (illegal_op),
      .state         (state)
   );

   assign w_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                    ir_write, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, mem_to_reg, reg_dst, illegal_op};

   // Expected control words, written out by hand from the state table.
   localparam logic [18:0] C_RST   = 19'b0_0_0_0_0_0_0_0_01_00_00_00_00_0;
   localparam logic [18:0] C_FETCH = 19'b1_0_0_1_0_1_0_0_01_00_00_00_00_0;
   localparam logic [18:0] C_FWAIT = 19'b0_0_0_1_0_0_0_0_01_00_00_00_00_0;
   localparam logic [18:0] C_DEC   = 19'b0_0_0_0_0_0_0_0_11_00_00_00_00_0;
   localparam logic [18:0] C_ILL   = 19'b0_0_0_0_0_0_0_0_11_00_00_00_00_1;
   localparam logic [18:0] C_MADDR = 19'b0_0_0_0_0_0_0_1_10_00_00_00_00_0;
   localparam logic [18:0] C_MRD   = 19'b0_0_1_1_0_0_0_0_00_00_00_00_00_0;
   localparam logic [18:0] C_MWB   = 19'b0_0_0_0_0_0_1_0_00_00_00_01_00_0;
   localparam logic [18:0] C_MWR   = 19'b0_0_1_0_1_0_0_0_00_00_00_00_00_0;
   localparam logic [18:0] C_EXR   = 19'b0_0_0_0_0_0_0_1_00_10_00_00_00_0;
   localparam logic [18:0] C_RWB   = 19'b0_0_0_0_0_0_1_0_00_00_00_00_01_0;
   localparam logic [18:0] C_BR    = 19'b0_1_0_0_0_0_0_1_00_01_01_00_00_0;
   localparam logic [18:0] C_JMP   = 19'b1_0_0_0_0_0_0_0_00_00_10_00_00_0;
   localparam logic [18:0] C_EXI   = 19'b0_0_0_0_0_0_0_1_10_00_00_00_00_0;
   localparam logic [18:0] C_IWB   = 19'b0_0_0_0_0_0_1_0_00_00_00_00_00_0;
`ifdef MC_CONTROL_JAL_EN
   localparam logic [18:0] C_JAL   = 19'b1_0_0_0_0_0_1_0_00_00_10_10_10_0;
`endif
   localparam logic [18:0] C_NONE  = 19'd0;

   // Instruction table, mem_ready held at 1. States are nibbles, first
   // state in the most significant nibble; control words likewise.
   logic [5:0]   seq_op  [0:5] = '{6'b100011, 6'b101011, 6'b000000,
                                   6'b001000, 6'b000100, 6'b000010};
   string        seq_nm  [0:5] = '{"lw", "sw", "r", "addi", "beq", "j"};
   int           seq_len [0:5] = '{6, 5, 5, 5, 4, 4};
   logic [23:0]  seq_st  [0:5] = '{24'h012340, 24'h012500, 24'h016700,
                                   24'h01AB00, 24'h018000, 24'h019000};
   logic [113:0] seq_ex  [0:5] = '{
      {C_FETCH, C_DEC, C_MADDR, C_MRD, C_MWB, C_FETCH},
      {C_FETCH, C_DEC, C_MADDR, C_MWR, C_FETCH, C_NONE},
      {C_FETCH, C_DEC, C_EXR, C_RWB, C_FETCH, C_NONE},
      {C_FETCH, C_DEC, C_EXI, C_IWB, C_FETCH, C_NONE},
      {C_FETCH, C_DEC, C_BR, C_FETCH, C_NONE, C_NONE},
      {C_FETCH, C_DEC, C_JMP, C_FETCH, C_NONE, C_NONE}};

   int n_checks = 0;
   int n_errors = 0;

   // --------------------------------------------------------------------------
   // Driver tasks
   // --------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // --------------------------------------------------------------------------
   // Scenarios
   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst       = 1'b1;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      step();
      step();
      n_checks++;
      if (state !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_state: got %0d expected 0", state);
      end
      n_checks++;
      if (w_ctrl !== C_RST) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b expected %b", w_ctrl, C_RST);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (w_ctrl !== C_FETCH) begin
         n_errors++;
         $display("FAIL reset_release_ctrl: got %b expected %b", w_ctrl, C_FETCH);
      end
   endtask

   // Runs every supported instruction back to back; each ends in FETCH,
   // which is also the first cycle of the next one.
   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         opcode = seq_op[k];
         #1;
         for (int i = 0; i < seq_len[k]; i++) begin
            n_checks++;
            if (state !== seq_st[k][(5-i)*4 +: 4]) begin
               n_errors++;
               $display("FAIL %s_state[%0d]: got %0d expected %0d", seq_nm[k], i,
                        state, seq_st[k][(5-i)*4 +: 4]);
            end
            n_checks++;
            if (w_ctrl !== seq_ex[k][(5-i)*19 +: 19]) begin
               n_errors++;
               $display("FAIL %s_ctrl[%0d]: got %b expected %b", seq_nm[k], i,
                        w_ctrl, seq_ex[k][(5-i)*19 +: 19]);
            end
            if (i < seq_len[k] - 1) step();
         end
      end
   endtask

   task automatic test_mem_wait();
      // Fetch stall: request held, nothing committed.
      mem_ready = 1'b0;
      opcode    = 6'b101011;
      #1;
      n_checks++;
      if (w_ctrl !== C_FWAIT) begin
         n_errors++;
         $display("FAIL fetch_wait_ctrl: got %b expected %b", w_ctrl, C_FWAIT);
      end
      step();
      n_checks++;
      if (state !== 4'd0) begin
         n_errors++;
         $display("FAIL fetch_wait_state: got %0d expected 0", state);
      end
      mem_ready = 1'b1;
      step();
      step();
      step();
      // Store stall: three not-ready cycles, then the completing one.
      mem_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_ready = 1'b1;
         #1;
         n_checks++;
         if (state !== 4'd5 || mem_write !== 1'b1) begin
            n_errors++;
            $display("FAIL sw_wait[%0d]: got state %0d mem_write %b expected 5/1",
                     c, state, mem_write);
         end
         step();
      end
      n_checks++;
      if (state !== 4'd0 || mem_write !== 1'b0) begin
         n_errors++;
         $display("FAIL sw_wait_done: got state %0d mem_write %b expected 0/0",
                  state, mem_write);
      end
   endtask

   task automatic test_illegal();
      opcode = 6'b111111;
      step();
      n_checks++;
      if (state !== 4'd1 || w_ctrl !== C_ILL) begin
         n_errors++;
         $display("FAIL illegal_decode: got state %0d ctrl %b expected 1 %b",
                  state, w_ctrl, C_ILL);
      end
      step();
      n_checks++;
      if (state !== 4'd0 || w_ctrl !== C_FETCH) begin
         n_errors++;
         $display("FAIL illegal_after: got state %0d ctrl %b expected 0 %b",
                  state, w_ctrl, C_FETCH);
      end
   endtask

   task automatic test_opcode_ignored();
      opcode = 6'b100011;
      step();
      step();
      step();
      opcode = 6'b000010;
      #1;
      n_checks++;
      if (state !== 4'd3 || w_ctrl !== C_MRD) begin
         n_errors++;
         $display("FAIL ignore_mem_read: got state %0d ctrl %b expected 3 %b",
                  state, w_ctrl, C_MRD);
      end
      step();
      n_checks++;
      if (state !== 4'd4 || w_ctrl !== C_MWB) begin
         n_errors++;
         $display("FAIL ignore_mem_wb: got state %0d ctrl %b expected 4 %b",
                  state, w_ctrl, C_MWB);
      end
      step();
      n_checks++;
      if (state !== 4'd0) begin
         n_errors++;
         $display("FAIL ignore_done: got state %0d expected 0", state);
      end
   endtask

   task automatic test_reset_mid_wait();
      opcode    = 6'b100011;
      mem_ready = 1'b1;
      step();
      step();
      step();
      mem_ready = 1'b0;
      step();
      n_checks++;
      if (state !== 4'd3 || mem_read !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mid_pre: got state %0d mem_read %b expected 3/1",
                  state, mem_read);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (w_ctrl !== C_RST) begin
         n_errors++;
         $display("FAIL rst_mid_ctrl: got %b expected %b", w_ctrl, C_RST);
      end
      step();
      n_checks++;
      if (state !== 4'd0 || mem_read !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid_state: got state %0d mem_read %b expected 0/0",
                  state, mem_read);
      end
      rst       = 1'b0;
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (w_ctrl !== C_FETCH) begin
         n_errors++;
         $display("FAIL rst_mid_release: got %b expected %b", w_ctrl, C_FETCH);
      end
   endtask

   task automatic test_jal();
      opcode = 6'b000011;
      step();
`ifdef MC_CONTROL_JAL_EN
      n_checks++;
      if (state !== 4'd1 || w_ctrl !== C_DEC) begin
         n_errors++;
         $display("FAIL jal_decode: got state %0d ctrl %b expected 1 %b",
                  state, w_ctrl, C_DEC);
      end
      step();
      n_checks++;
      if (state !== 4'd12 || w_ctrl !== C_JAL) begin
         n_errors++;
         $display("FAIL jal_state: got state %0d ctrl %b expected 12 %b",
                  state, w_ctrl, C_JAL);
      end
`else
      n_checks++;
      if (state !== 4'd1 || w_ctrl !== C_ILL) begin
         n_errors++;
         $display("FAIL jal_illegal: got state %0d ctrl %b expected 1 %b",
                  state, w_ctrl, C_ILL);
      end
`endif
      step();
      n_checks++;
      if (state !== 4'd0) begin
         n_errors++;
         $display("FAIL jal_done: got state %0d expected 0", state);
      end
   endtask

   // --------------------------------------------------------------------------
   // Sequence and report
   // --------------------------------------------------------------------------
   initial begin
      test_reset();
      test_back_to_back();
      test_mem_wait();
      test_illegal();
      test_opcode_ignored();
      test_reset_mid_wait();
      test_jal();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode width.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port opcode  input  OP_W  instruction-register opcode field.
REQ-005 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL have ports pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a  output  1 each  datapath enables/selects.
REQ-007 SHALL have ports alu_src_b, alu_op, pc_source, mem_to_reg, reg_dst  output  2 each  4:1 mux selects / ALU op class.
REQ-008 SHALL have port illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-009 SHALL have port state  output  4  current state, debug.

Function
REQ-010 SHALL implement a Moore FSM, encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, JAL=12; codes 13-15 go to FETCH next cycle.
REQ-011 SHALL decode opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000, JAL=000011.
REQ-012 SHALL in FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; stay in FETCH until mem_ready=1, then DECODE.
REQ-013 SHALL in DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next LW/SW->MEM_ADDR, R->EXEC_R, BEQ->BRANCH, J->JUMP, ADDI->EXEC_I, JAL->JAL (macro only), other->FETCH with illegal_op=1 this cycle.
REQ-014 SHALL in MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next LW->MEM_READ, SW->MEM_WRITE.
REQ-015 SHALL in MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB.
REQ-016 SHALL in MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; next FETCH.
REQ-017 SHALL in MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-018 SHALL in EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB; R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; next FETCH.
REQ-019 SHALL in BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
REQ-020 SHALL in JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-021 SHALL in EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00; next I_WB; I_WB: reg_write=1, reg_dst=00, mem_to_reg=00; next FETCH.
REQ-022 SHALL drive every output not listed for a state to 0.
REQ-023 SHALL sample opcode only in DECODE and MEM_ADDR; opcode changes elsewhere have no effect.
REQ-024 SHALL give latencies with mem_ready always 1: LW 5 cycles, SW/R/ADDI 4, BEQ/J 3.

Reset
REQ-025 SHALL load state=FETCH on any rising clk edge with rst=1, including mid-instruction and mid-memory-wait.
REQ-026 SHALL force all 1-bit enables (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) and illegal_op to 0 while rst=1; selects take FETCH values.

Configuration
REQ-027 SHALL, with macro MC_CONTROL_JAL_EN defined, support JAL: JAL state drives reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10; next FETCH.
REQ-028 SHALL, without MC_CONTROL_JAL_EN, treat 000011 as illegal (REQ-013) and never reach encoding 12.

Verification
REQ-029 SHALL test: rst=1 two cycles, mem_ready=1 -> state=0, all enables 0; first cycle after release mem_read=1, ir_write=1, pc_write=1.
REQ-030 SHALL test: LW, mem_ready=1 -> states 0,1,2,3,4,0; MEM_WB has reg_write=1, mem_to_reg=01.
REQ-031 SHALL test: SW, mem_ready low 3 cycles in MEM_WRITE -> mem_write=1 held 4 cycles, then state=0.
REQ-032 SHALL test: opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state=0, no write enable asserted.
REQ-033 SHALL test: rst=1 during MEM_READ wait -> next state=0, mem_read=0 during reset.
REQ-034 SHALL test: JAL with macro -> state 12, reg_dst=10, pc_source=10; without macro -> illegal_op=1.
